// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel-array frame sequencer.
// The phase-strobe decode lives here so controller and checkers agree on strobe order.
package pixel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    READ1   = 3'd4,
    READ2   = 3'd5,
    CAPTURE = 3'd6,
    STREAM  = 3'd7
  } frame_state_t;

  localparam int DEF_C_ERASE   = 5;
  localparam int DEF_C_CONVERT = 255;
  localparam int DEF_C_READ    = 5;
  localparam int DEF_EXP_W     = 16;
  localparam int PIX_COUNT     = 4;
  localparam int PIX_W         = 8;
  localparam int IDX_W         = $clog2(PIX_COUNT);

  // Strobe vector order: {erase, expose, convert, read1, read2}
  function automatic logic [4:0] strobeDecode(frame_state_t s);
    logic [4:0] v;
    case (s)
      ERASE:   v = 5'b10000;
      EXPOSE:  v = 5'b01000;
      CONVERT: v = 5'b00100;
      READ1:   v = 5'b00010;
      READ2:   v = 5'b00001;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

  function automatic logic isPhase(frame_state_t s);
    return (s == ERASE) || (s == EXPOSE) || (s == CONVERT) || (s == READ1) || (s == READ2);
  endfunction

endpackage

// File: rtl/pixel_stream_buf.sv
// 4x8 holding buffer and valid/ready byte serializer for one captured frame.
// lastAccept flags the handshake of the final byte so the sequencer can close the frame.
module pixel_stream_buf
  import pixel_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PIX_W-1:0] pixIn1,
  input  logic [PIX_W-1:0] pixIn2,
  input  logic [PIX_W-1:0] pixIn3,
  input  logic [PIX_W-1:0] pixIn4,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             lastAccept
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_COUNT - 1);

  logic [PIX_W-1:0] holdR [PIX_COUNT];
  logic [IDX_W-1:0] idxR;
  logic [PIX_W-1:0] dataR;
  logic             validR;
  logic             lastR;

  // Capture the array bytes on load, then step through them one handshake at a time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIX_COUNT; i++) begin
        holdR[i] <= '0;
      end
      idxR   <= '0;
      dataR  <= '0;
      validR <= 1'b0;
      lastR  <= 1'b0;
    end else if (load) begin
      holdR[0] <= pixIn1;
      holdR[1] <= pixIn2;
      holdR[2] <= pixIn3;
      holdR[3] <= pixIn4;
      dataR    <= pixIn1;
      validR   <= 1'b1;
      lastR    <= 1'b0;
      idxR     <= '0;
    end else if (validR && out_ready) begin
      if (idxR == LAST_IDX) begin
        validR <= 1'b0;
        lastR  <= 1'b0;
        idxR   <= '0;
      end else begin
        idxR  <= idxR + IDX_W'(1);
        dataR <= holdR[idxR + IDX_W'(1)];
        lastR <= (idxR + IDX_W'(1)) == LAST_IDX;
      end
    end
  end

  assign out_data   = dataR;
  assign out_valid  = validR;
  assign out_last   = lastR;
  assign lastAccept = validR && out_ready && lastR;

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: erase/expose/convert/read1/read2 timing for the 2x2 pixel array,
// followed by capture and valid/ready streaming of the four pixel bytes.
module pixel_frame_ctrl
  import pixel_pkg::*;
#(
  parameter int C_ERASE   = DEF_C_ERASE,
  parameter int C_CONVERT = DEF_C_CONVERT,
  parameter int C_READ    = DEF_C_READ,
  parameter int EXP_W     = DEF_EXP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [EXP_W-1:0] exp_time,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic             read1,
  output logic             read2,
  input  logic [PIX_W-1:0] pixIn1,
  input  logic [PIX_W-1:0] pixIn2,
  input  logic [PIX_W-1:0] pixIn3,
  input  logic [PIX_W-1:0] pixIn4,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = (EXP_W > 16) ? EXP_W : 16;

  frame_state_t     stateR, nextS;
  logic [CNT_W-1:0] cntR, durS;
  logic [EXP_W-1:0] expR;
  logic             phaseEndS, lastAcceptS, loadS, frameStartS;
  logic [4:0]       strobeNextS, strobeR;
  logic             busyNextS, busyR, frameDoneR;

  // Duration of the phase currently running
  always_comb begin
    durS = CNT_W'(1);
    case (stateR)
      ERASE:   durS = CNT_W'(C_ERASE);
      EXPOSE:  durS = CNT_W'(expR);
      CONVERT: durS = CNT_W'(C_CONVERT);
      READ1:   durS = CNT_W'(C_READ);
      READ2:   durS = CNT_W'(C_READ);
      default: durS = CNT_W'(1);
    endcase
  end

  assign phaseEndS   = (cntR == durS - CNT_W'(1));
  assign loadS       = (stateR == CAPTURE);
  assign frameStartS = (nextS == ERASE) && ((stateR == IDLE) || (stateR == STREAM));

  // State register, phase counter and exposure latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR <= IDLE;
      cntR   <= '0;
      expR   <= '0;
    end else begin
      stateR <= nextS;
      cntR   <= ((nextS == stateR) && isPhase(stateR)) ? cntR + CNT_W'(1) : '0;
      if (frameStartS) begin
        expR <= (exp_time == '0) ? EXP_W'(1) : exp_time;
      end
    end
  end

  // Next-state logic
  always_comb begin
    nextS = stateR;
    case (stateR)
      IDLE:    nextS = start ? ERASE : IDLE;
      ERASE:   nextS = phaseEndS ? EXPOSE : ERASE;
      EXPOSE:  nextS = phaseEndS ? CONVERT : EXPOSE;
      CONVERT: nextS = phaseEndS ? READ1 : CONVERT;
      READ1:   nextS = phaseEndS ? READ2 : READ1;
      READ2:   nextS = phaseEndS ? CAPTURE : READ2;
      CAPTURE: nextS = STREAM;
      STREAM: begin
        if (lastAcceptS) begin
          nextS = continuous ? ERASE : IDLE;
        end else begin
          nextS = STREAM;
        end
      end
      default: nextS = IDLE;
    endcase
  end

  // Output decode from the upcoming state so strobes line up with their state
  always_comb begin
    strobeNextS = strobeDecode(nextS);
    busyNextS   = (nextS != IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobeR    <= 5'b00000;
      busyR      <= 1'b0;
      frameDoneR <= 1'b0;
    end else begin
      strobeR    <= strobeNextS;
      busyR      <= busyNextS;
      frameDoneR <= lastAcceptS;
    end
  end

  assign {erase, expose, convert, read1, read2} = strobeR;
  assign busy       = busyR;
  assign frame_done = frameDoneR;

  pixel_stream_buf uStreamBuf (
    .clk        (clk),
    .reset      (reset),
    .load       (loadS),
    .pixIn1     (pixIn1),
    .pixIn2     (pixIn2),
    .pixIn3     (pixIn3),
    .pixIn4     (pixIn4),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .lastAccept (lastAcceptS)
  );

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Bench for pixel_frame_ctrl: each frame is modelled as a schedule of strobe
// patterns built from the phase lengths, plus a queue of bytes to be streamed.
module tb_pixel_frame_ctrl;

  localparam int CE = 5;
  localparam int CC = 255;
  localparam int CR = 5;
  localparam int EW = 16;
  localparam int M_IDLE = 0;
  localparam int M_PH = 1;
  localparam int M_STREAM = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [EW-1:0] exp_time = '0;
  logic          erase, expose, convert, read1, read2;
  logic [7:0]    pixIn1 = 8'h7F, pixIn2 = 8'h3C, pixIn3 = 8'hFF, pixIn4 = 8'h00;
  logic [7:0]    out_data;
  logic          out_valid, out_last, busy, frame_done;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  pixel_frame_ctrl #(.C_ERASE(CE), .C_CONVERT(CC), .C_READ(CR), .EXP_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .exp_time(exp_time),
    .erase(erase), .expose(expose), .convert(convert), .read1(read1), .read2(read2),
    .pixIn1(pixIn1), .pixIn2(pixIn2), .pixIn3(pixIn3), .pixIn4(pixIn4),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  int vecCnt = 0;
  int errCnt = 0;

  // reference model state
  int         mMode = M_IDLE;
  logic [4:0] sched[$];
  logic [7:0] bytesQ[$];
  logic [4:0] curStrobe = 5'b00000;
  logic       expDone = 1'b0;

  // per-frame tallies and stimulus controls
  int   cycNo = 0, firstErase = -1, firstDone = -1, doneCnt = 0, accCnt = 0;
  int   strobeCnt[5];
  logic prevErase = 1'b0;
  int   readyMode = 0, stallCnt = 0;
  logic randPix = 1'b0, randCtl = 1'b0;

  task automatic checkEq(string tag, logic [31:0] got, logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic newFrame(logic [EW-1:0] e);
    int ee;
    ee = (e == '0) ? 1 : int'(e);
    sched.delete();
    repeat (CE) sched.push_back(5'b10000);
    repeat (ee) sched.push_back(5'b01000);
    repeat (CC) sched.push_back(5'b00100);
    repeat (CR) sched.push_back(5'b00010);
    repeat (CR) sched.push_back(5'b00001);
    sched.push_back(5'b00000);
    mMode = M_PH;
  endtask

  task automatic modelStep();
    logic done;
    done = 1'b0;
    if (!reset) begin
      mMode = M_IDLE;
      sched.delete();
      bytesQ.delete();
    end else begin
      case (mMode)
        M_IDLE: if (start) newFrame(exp_time);
        M_PH: begin
          if (sched.size() == 0) begin
            mMode = M_STREAM;
            bytesQ.delete();
            bytesQ.push_back(pixIn1);
            bytesQ.push_back(pixIn2);
            bytesQ.push_back(pixIn3);
            bytesQ.push_back(pixIn4);
          end
        end
        default: begin
          if (out_ready) begin
            void'(bytesQ.pop_front());
            if (bytesQ.size() == 0) begin
              done = 1'b1;
              if (continuous) newFrame(exp_time);
              else mMode = M_IDLE;
            end
          end
        end
      endcase
    end
    curStrobe = (mMode == M_PH) ? sched.pop_front() : 5'b00000;
    expDone = done;
  endtask

  task automatic driveInputs();
    case (readyMode)
      0: out_ready = 1'b1;
      1: begin
        if (mMode == M_STREAM) begin
          stallCnt++;
          out_ready = (stallCnt > 20) ? stallCnt[0] : 1'b0;
        end else begin
          stallCnt = 0;
          out_ready = 1'b0;
        end
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (randPix) begin
      pixIn1 = 8'($urandom);
      pixIn2 = 8'($urandom);
      pixIn3 = 8'($urandom);
      pixIn4 = 8'($urandom);
    end
    if (randCtl) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) continuous = ~continuous;
      if ($urandom_range(0, 15) == 0) exp_time = EW'($urandom_range(0, 12));
    end
  endtask

  task automatic tick();
    logic [16:0] dutV, expV;
    logic [7:0]  expData;
    if (out_valid && out_ready) accCnt++;
    @(posedge clk);
    modelStep();
    #1;
    cycNo++;
    expData = 8'h00;
    if (mMode == M_STREAM && bytesQ.size() > 0) expData = bytesQ[0];
    dutV = {erase, expose, convert, read1, read2, busy, out_valid, out_last, frame_done,
            out_valid ? out_data : 8'h00};
    expV = {curStrobe, mMode != M_IDLE, mMode == M_STREAM,
            (mMode == M_STREAM) && (bytesQ.size() == 1), expDone, expData};
    checkEq("cycle", 32'(dutV), 32'(expV));
    if (erase && !prevErase && firstErase < 0) firstErase = cycNo;
    prevErase = erase;
    strobeCnt[0] += int'(erase);
    strobeCnt[1] += int'(expose);
    strobeCnt[2] += int'(convert);
    strobeCnt[3] += int'(read1);
    strobeCnt[4] += int'(read2);
    if (frame_done) begin
      doneCnt++;
      if (firstDone < 0) firstDone = cycNo;
    end
    driveInputs();
  endtask

  task automatic clrCounts();
    firstErase = -1;
    firstDone = -1;
    doneCnt = 0;
    accCnt = 0;
    for (int i = 0; i < 5; i++) strobeCnt[i] = 0;
  endtask

  task automatic waitIdle(string tag, int limit);
    int n;
    n = 0;
    while ((busy || mMode != M_IDLE) && n < limit) begin
      tick();
      n++;
    end
    checkEq(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) tick();
    checkEq("rstData", 32'(out_data), 32'd0);
    reset = 1'b1;
    repeat (3) tick();

    // single frame, exp 10
    clrCounts();
    exp_time = 16'd10;
    pulseStart();
    waitIdle("frame1Timeout", 400);
    checkEq("eraseLen", strobeCnt[0], CE);
    checkEq("exposeLen", strobeCnt[1], 10);
    checkEq("convertLen", strobeCnt[2], CC);
    checkEq("read1Len", strobeCnt[3], CR);
    checkEq("read2Len", strobeCnt[4], CR);
    checkEq("frame1Done", doneCnt, 1);
    checkEq("frameLen", firstDone - firstErase, CE + 10 + CC + 2 * CR + 1 + 4);
    checkEq("frame1Bytes", accCnt, 4);

    // backpressure
    clrCounts();
    readyMode = 1;
    stallCnt = 0;
    pulseStart();
    waitIdle("bpTimeout", 600);
    checkEq("bpBytes", accCnt, 4);
    checkEq("bpDone", doneCnt, 1);
    readyMode = 0;

    // continuous mode, exp 3, cleared during frame 3
    clrCounts();
    exp_time = 16'd3;
    continuous = 1'b1;
    pulseStart();
    for (int n = 0; n < 2000 && doneCnt < 2; n++) tick();
    repeat (50) tick();
    continuous = 1'b0;
    waitIdle("contTimeout", 600);
    checkEq("contFrames", doneCnt, 3);
    checkEq("contBytes", accCnt, 12);

    // exp 0 and start during CONVERT
    clrCounts();
    exp_time = 16'd0;
    pulseStart();
    repeat (30) tick();
    pulseStart();
    waitIdle("exp0Timeout", 400);
    repeat (5) tick();
    checkEq("exp0Len", strobeCnt[1], 1);
    checkEq("exp0Frames", doneCnt, 1);

    // exp_time change mid-EXPOSE
    clrCounts();
    exp_time = 16'd20;
    pulseStart();
    repeat (8) tick();
    exp_time = 16'd50;
    waitIdle("expHoldTimeout", 400);
    checkEq("expHoldLen", strobeCnt[1], 20);

    // async reset during CONVERT
    exp_time = 16'd10;
    pulseStart();
    repeat (99) tick();
    #3 reset = 1'b0;
    #1;
    checkEq("arstOut", 32'({erase, expose, convert, read1, read2, busy, out_valid,
                            out_last, frame_done, out_data}), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    clrCounts();
    pulseStart();
    waitIdle("postRstTimeout", 400);
    checkEq("postRstLen", firstDone - firstErase, CE + 10 + CC + 2 * CR + 1 + 4);
    checkEq("postRstBytes", accCnt, 4);

    // randomized traffic
    randPix = 1'b1;
    randCtl = 1'b1;
    readyMode = 2;
    repeat (4000) tick();
    randCtl = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    readyMode = 0;
    waitIdle("randTimeout", 800);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
